spi_minion: RTL and testbench
=============================

# spi_minion

SPI mode-0 minion (peripheral) endpoint: the far end of the team's SPI master link. It oversamples the external `sclk`/`cs`/`mosi` pins in the system clock domain and deserializes fixed-size packets from `mosi` onto a val/rdy send interface. It simultaneously serializes a packet taken from a val/rdy recv interface onto `miso`. It sits at the chip pad boundary and feeds the same on-chip val/rdy fabric the master uses.

## Interface
- `nbits`, 34, packet width in bits; every transaction is exactly `nbits` sclk cycles.
- `nsync`, 2, synchronizer flop depth on `cs`, `sclk`, `mosi` (≥2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spi_ifc_cs`  in  1  chip select, active low, asynchronous to `clk`.
- `spi_ifc_sclk`  in  1  SPI clock from master, asynchronous to `clk`.
- `spi_ifc_mosi`  in  1  serial data from master.
- `spi_ifc_miso`  out  1  serial data to master.
- `recv_val`/`recv_rdy`/`recv_msg`  in/out/in  1/1/`nbits`  next packet to transmit on miso.
- `send_val`/`send_rdy`/`send_msg`  out/in/out  1/1/`nbits`  packet received on mosi.
- `overflow`  out  1  sticky: a complete packet was dropped because the send buffer was full.
- `underflow`  out  1  sticky: a transaction started with no recv packet buffered.
- `flag_clr`  in  1  synchronous clear of both sticky flags.

## Operation
- Sync: `cs`, `sclk`, `mosi` each pass through `nsync` flops; one more register on sync `sclk`/`cs` gives the previous value for edge detect. `mosi` uses the same delay so it aligns with `sclk`.
- TX buffer: one entry. `recv_rdy` = buffer empty. Accept on `recv_val & recv_rdy`.
- RX buffer: one entry. `send_val` = buffer full; `send_msg` = buffer contents; it empties on `send_val & send_rdy`.
- FSM states:
  - IDLE: sync cs high. On sync cs falling, load the TX shift register from the TX buffer and empty the buffer. If the buffer is empty, load all zeros and set `underflow`. Clear the RX shift register and bit counter, then go to SHIFT.
  - SHIFT:
    - Sync sclk rising: shift sync mosi into the RX shift register LSB and increment the counter.
    - Sync sclk falling: shift the TX register left by one, filling with 0.
    - When the counter reaches `nbits` on a rising edge: if the RX buffer is empty, the completed word (including the bit just sampled) is written into it the next cycle; otherwise drop the word and set `overflow`. Then go to WAIT_CS.
  - WAIT_CS: ignore all sclk edges; on sync cs rising go to IDLE.
- Sync cs rising in SHIFT before `nbits` bits (abort): discard the partial packet, set no flag, go to IDLE. The TX packet already consumed is lost.
- `miso` = TX shift register MSB while the FSM is in SHIFT or WAIT_CS, else 0. Bits go MSB first in both directions.
- Bit counter is `$clog2(nbits)+1` bits wide and never wraps (saturates at `nbits`).
- Simultaneous events:
  - A `send_rdy` dequeue in the same cycle as packet completion frees the buffer first, so the packet is accepted with no overflow.
  - A `recv_val` enqueue in the same cycle as a cs-fall load does not count: the buffer was empty, so underflow is set, and the new packet is held for the next transaction.
  - `flag_clr` in the same cycle as a flag-set event: set wins.

## Timing
- Reset values: `recv_rdy`=1, `send_val`=0, `send_msg`=0, `miso`=0, `overflow`=0, `underflow`=0, FSM=IDLE, synchronizer flops=1 for cs and 0 for sclk/mosi.
- Pin-to-action latency: `nsync`+1 clk cycles from a pin edge to the resulting internal action.
- Master constraints: sclk high and low phases ≥ `nsync`+2 clk periods each; cs fall to first sclk rise ≥ `nsync`+3 clk periods, so miso's MSB is valid before the first sample.
- `send_val` rises 1 clk after the detected `nbits`-th sclk rising edge.
- `recv_rdy` rises 1 clk after the cs-fall load.
- Reset mid-transaction: everything returns to reset values immediately. After release, the FSM stays in IDLE until a fresh cs falling edge; a cs already held low is not treated as a start.

## Test plan
- Reset, then master sends 0x2_AAAA_5555 with recv buffer holding 0x1_2345_6789 -> `send_msg`=0x2_AAAA_5555, `send_val`=1; master captures 0x1_2345_6789; no flags.
- Three back-to-back packets with `send_rdy`=0 -> first held in `send_msg`, second and third dropped, `overflow`=1. With `send_rdy` tied high instead -> all three delivered, `overflow`=0.
- Transaction with no recv packet loaded -> master reads all zeros, `underflow`=1; `flag_clr` pulse -> `underflow`=0.
- cs raised after 10 sclk cycles -> `send_val` stays 0, no flags; the next full packet 0x0_0000_0001 is received correctly.
- `reset` asserted at bit 17 -> all outputs at reset values within the same cycle; a full packet after release is received intact.
- 40 sclk cycles inside one cs window -> only the first 34 bits are delivered, and extra edges do not corrupt the RX buffer.

Source files
------------

// File: rtl/spi_minion_if.sv
// spi_minion_if: pad-side SPI pins plus the on-chip val/rdy send/recv channels
// and the sticky status flags of the SPI minion endpoint.
//   slave  : view taken by spi_minion (samples pins, drives miso and send side)
//   master : view taken by whatever drives the pins and the val/rdy fabric
interface spi_minion_if #(
  parameter int unsigned nbits = 34
);
  logic             spi_ifc_cs;
  logic             spi_ifc_sclk;
  logic             spi_ifc_mosi;
  logic             spi_ifc_miso;
  logic             recv_val;
  logic             recv_rdy;
  logic [nbits-1:0] recv_msg;
  logic             send_val;
  logic             send_rdy;
  logic [nbits-1:0] send_msg;
  logic             overflow;
  logic             underflow;
  logic             flag_clr;

  modport slave (
    input  spi_ifc_cs, spi_ifc_sclk, spi_ifc_mosi, recv_val, recv_msg, send_rdy, flag_clr,
    output spi_ifc_miso, recv_rdy, send_val, send_msg, overflow, underflow
  );

  modport master (
    output spi_ifc_cs, spi_ifc_sclk, spi_ifc_mosi, recv_val, recv_msg, send_rdy, flag_clr,
    input  spi_ifc_miso, recv_rdy, send_val, send_msg, overflow, underflow
  );
endinterface

// File: rtl/spi_minion.sv
// spi_minion: SPI mode-0 minion endpoint. Oversamples cs/sclk/mosi in the clk
// domain, deserializes nbits-bit packets from mosi into a one-entry send
// buffer and serializes a packet from a one-entry recv buffer onto miso,
// MSB first in both directions.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : spi_minion_if.slave (SPI pins, recv/send val/rdy, overflow,
//           underflow, flag_clr)
module spi_minion #(
  parameter int unsigned nbits = 34,
  parameter int unsigned nsync = 2
) (
  input logic        clk,
  input logic        reset,
  spi_minion_if.slave bus
);

  localparam int unsigned CntW = $clog2(nbits) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

  state_e state_q, state_d;

  // Synchronizers and edge-detect history
  logic [nsync-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic             cs_prev_q, sclk_prev_q;
  logic             cs_s, sclk_s, mosi_s;
  logic             cs_fall, cs_rise, sclk_rise, sclk_fall;

  // After reset the cs synchronizer holds its reset value, not a real sample.
  // warm_q marks when the chain carries real samples; armed_q then waits for
  // cs to be seen high so a cs held low across reset is not taken as a start.
  logic [nsync:0]   warm_q;
  logic             armed_q;

  // Datapath
  logic [nbits-1:0] tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d;
  logic [nbits-1:0] tx_shift_q, tx_shift_d;
  logic [nbits-2:0] rx_shift_q, rx_shift_d;  // first nbits-1 bits; last bit joins at completion
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [nbits-1:0] rx_buf_q, rx_buf_d;
  logic             rx_full_q, rx_full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             tx_enq, tx_load, rx_deq, rx_space, rx_write, ovf_set, unf_set;
  logic [nbits-1:0] rx_word;

  assign cs_s   = cs_sync_q[nsync-1];
  assign sclk_s = sclk_sync_q[nsync-1];
  assign mosi_s = mosi_sync_q[nsync-1];

  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[nsync-2:0], bus.spi_ifc_cs};
      sclk_sync_q <= {sclk_sync_q[nsync-2:0], bus.spi_ifc_sclk};
      mosi_sync_q <= {mosi_sync_q[nsync-2:0], bus.spi_ifc_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      warm_q      <= {warm_q[nsync-1:0], 1'b1};
      armed_q     <= armed_q | (warm_q[nsync] & cs_s);
    end
  end

  assign tx_enq   = bus.recv_val & ~tx_full_q;
  assign rx_deq   = rx_full_q & bus.send_rdy;
  assign rx_space = ~rx_full_q | rx_deq;  // same-cycle dequeue frees the slot first
  assign rx_word  = {rx_shift_q, mosi_s};

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cnt_d      = cnt_q;
    tx_load    = 1'b0;
    rx_write   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          tx_load    = 1'b1;
          tx_shift_d = tx_full_q ? tx_buf_q : '0;
          unf_set    = ~tx_full_q;
          rx_shift_d = '0;
          cnt_d      = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          // Abort: partial packet discarded, consumed TX packet is lost
          state_d = StIdle;
        end else if (sclk_rise) begin
          rx_shift_d = rx_word[nbits-2:0];
          if (cnt_q != CntW'(nbits)) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(nbits - 1)) begin
            rx_write = rx_space;
            ovf_set  = ~rx_space;
            state_d  = StWaitCs;
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[nbits-2:0], 1'b0};
        end
      end
      StWaitCs: begin
        if (cs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A recv enqueue coinciding with a load only happens when the buffer was
  // empty, so it lands in the buffer for the next transaction.
  assign tx_full_d   = (tx_full_q & ~tx_load) | tx_enq;
  assign tx_buf_d    = tx_enq ? bus.recv_msg : tx_buf_q;
  assign rx_full_d   = rx_write | (rx_full_q & ~rx_deq);
  assign rx_buf_d    = rx_write ? rx_word : rx_buf_q;
  assign overflow_d  = ovf_set | (overflow_q & ~bus.flag_clr);
  assign underflow_d = unf_set | (underflow_q & ~bus.flag_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      cnt_q       <= '0;
      rx_buf_q    <= '0;
      rx_full_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      cnt_q       <= cnt_d;
      rx_buf_q    <= rx_buf_d;
      rx_full_q   <= rx_full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.spi_ifc_miso = (state_q != StIdle) & tx_shift_q[nbits-1];
  assign bus.recv_rdy     = ~tx_full_q;
  assign bus.send_val     = rx_full_q;
  assign bus.send_msg     = rx_buf_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_spi_minion.sv
// tb_spi_minion: directed bench for spi_minion. A behavioural SPI mode-0
// master drives the pins (half sclk period = 6 clk), the bench feeds the
// recv channel and inspects the send channel and flags.
module tb_spi_minion;

  localparam int unsigned NBits = 34;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  spi_minion_if #(.nbits(NBits)) bus ();

  spi_minion #(
    .nbits(NBits),
    .nsync(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Deliveries observed while send_rdy is high
  logic [NBits-1:0] got_q[$];
  always @(negedge clk) begin
    if (bus.send_val && bus.send_rdy) got_q.push_back(bus.send_msg);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_recv(input logic [NBits-1:0] msg);
    bus.recv_val = 1'b1;
    bus.recv_msg = msg;
    wait_clks(1);
    bus.recv_val = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.flag_clr = 1'b1;
    wait_clks(1);
    bus.flag_clr = 1'b0;
  endtask

  task automatic pop_send();
    bus.send_rdy = 1'b1;
    wait_clks(1);
    bus.send_rdy = 1'b0;
  endtask

  // Master transaction: nclk sclk cycles, bits past NBits drive mosi high.
  task automatic spi_xfer(input logic [NBits-1:0] tx, input int nclk, input bit raise_cs,
                          output logic [NBits-1:0] rx);
    logic [NBits-1:0] sh;
    sh = tx;
    rx = '0;
    bus.spi_ifc_cs = 1'b0;
    wait_clks(8);
    for (int i = 0; i < nclk; i++) begin
      bus.spi_ifc_mosi = sh[NBits-1];
      sh = {sh[NBits-2:0], 1'b1};
      wait_clks(6);
      if (i < int'(NBits)) rx = {rx[NBits-2:0], bus.spi_ifc_miso};
      bus.spi_ifc_sclk = 1'b1;
      wait_clks(6);
      bus.spi_ifc_sclk = 1'b0;
    end
    wait_clks(6);
    if (raise_cs) begin
      bus.spi_ifc_cs   = 1'b1;
      bus.spi_ifc_mosi = 1'b0;
      wait_clks(8);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.recv_rdy !== 1'b1) begin failures++;
      $display("FAIL reset_recv_rdy got=%b exp=1", bus.recv_rdy); end
    checks++; if (bus.send_val !== 1'b0) begin failures++;
      $display("FAIL reset_send_val got=%b exp=0", bus.send_val); end
    checks++; if (bus.send_msg !== '0) begin failures++;
      $display("FAIL reset_send_msg got=%h exp=0", bus.send_msg); end
    checks++; if (bus.spi_ifc_miso !== 1'b0) begin failures++;
      $display("FAIL reset_miso got=%b exp=0", bus.spi_ifc_miso); end
    checks++; if (bus.overflow !== 1'b0) begin failures++;
      $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin failures++;
      $display("FAIL reset_underflow got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_basic();
    logic [NBits-1:0] cap;
    push_recv(34'h1_2345_6789);
    checks++; if (bus.recv_rdy !== 1'b0) begin failures++;
      $display("FAIL basic_recv_full got=%b exp=0", bus.recv_rdy); end
    spi_xfer(34'h2_AAAA_5555, NBits, 1'b1, cap);
    checks++; if (bus.send_val !== 1'b1) begin failures++;
      $display("FAIL basic_send_val got=%b exp=1", bus.send_val); end
    checks++; if (bus.send_msg !== 34'h2_AAAA_5555) begin failures++;
      $display("FAIL basic_send_msg got=%h exp=%h", bus.send_msg, 34'h2_AAAA_5555); end
    checks++; if (cap !== 34'h1_2345_6789) begin failures++;
      $display("FAIL basic_miso got=%h exp=%h", cap, 34'h1_2345_6789); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++;
      $display("FAIL basic_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
    checks++; if (bus.recv_rdy !== 1'b1) begin failures++;
      $display("FAIL basic_recv_rdy got=%b exp=1", bus.recv_rdy); end
    pop_send();
    checks++; if (bus.send_val !== 1'b0) begin failures++;
      $display("FAIL basic_dequeue got=%b exp=0", bus.send_val); end
  endtask

  task automatic test_back_to_back();
    logic [NBits-1:0] cap;
    logic [NBits-1:0] pk[3];
    pk[0] = 34'h1_1111_1111;
    pk[1] = 34'h2_2222_2222;
    pk[2] = 34'h3_3333_3333;
    for (int i = 0; i < 3; i++) spi_xfer(pk[i], NBits, 1'b1, cap);
    checks++; if (bus.send_msg !== 34'h1_1111_1111) begin failures++;
      $display("FAIL b2b_held got=%h exp=%h", bus.send_msg, 34'h1_1111_1111); end
    checks++; if (bus.overflow !== 1'b1) begin failures++;
      $display("FAIL b2b_overflow got=%b exp=1", bus.overflow); end
    pulse_clr();
    pop_send();
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++;
      $display("FAIL b2b_clr got=%b exp=00", {bus.overflow, bus.underflow}); end
    // send_rdy tied high: every packet delivered
    got_q.delete();
    bus.send_rdy = 1'b1;
    pk[0] = 34'h0_CAFE_F00D;
    pk[1] = 34'h3_0000_0001;
    pk[2] = 34'h1_FFFF_0000;
    for (int i = 0; i < 3; i++) spi_xfer(pk[i], NBits, 1'b1, cap);
    bus.send_rdy = 1'b0;
    checks++; if (got_q.size() !== 3) begin failures++;
      $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== pk[i]) begin failures++;
          $display("FAIL b2b_pkt%0d got=%h exp=%h", i, got_q[i], pk[i]); end
      end
    end
    checks++; if (bus.overflow !== 1'b0) begin failures++;
      $display("FAIL b2b_no_overflow got=%b exp=0", bus.overflow); end
    pulse_clr();
  endtask

  task automatic test_underflow();
    logic [NBits-1:0] cap;
    spi_xfer(34'h0_1234_0000, NBits, 1'b1, cap);
    checks++; if (cap !== '0) begin failures++;
      $display("FAIL unf_miso got=%h exp=0", cap); end
    checks++; if (bus.underflow !== 1'b1) begin failures++;
      $display("FAIL unf_flag got=%b exp=1", bus.underflow); end
    pulse_clr();
    checks++; if (bus.underflow !== 1'b0) begin failures++;
      $display("FAIL unf_clear got=%b exp=0", bus.underflow); end
    pop_send();
  endtask

  task automatic test_abort();
    logic [NBits-1:0] cap;
    push_recv(34'h3_0F0F_0F0F);
    spi_xfer(34'h2_FFFF_FFFF, 10, 1'b1, cap);
    checks++; if (bus.send_val !== 1'b0) begin failures++;
      $display("FAIL abort_send_val got=%b exp=0", bus.send_val); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++;
      $display("FAIL abort_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
    checks++; if (bus.recv_rdy !== 1'b1) begin failures++;
      $display("FAIL abort_consumed got=%b exp=1", bus.recv_rdy); end
    push_recv(34'h0_5555_AAAA);
    spi_xfer(34'h0_0000_0001, NBits, 1'b1, cap);
    checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 34'h0_0000_0001) begin failures++;
      $display("FAIL abort_next got=%b/%h exp=1/%h", bus.send_val, bus.send_msg, 34'h1); end
    checks++; if (cap !== 34'h0_5555_AAAA) begin failures++;
      $display("FAIL abort_next_miso got=%h exp=%h", cap, 34'h0_5555_AAAA); end
    // leave the packet buffered so the reset test sees send_val fall
  endtask

  task automatic test_reset_mid();
    logic [NBits-1:0] cap;
    push_recv(34'h3_FFFF_FFFF);
    spi_xfer(34'h1_0000_0000, 17, 1'b0, cap);
    reset = 1'b0;
    #1;
    checks++; if (bus.send_val !== 1'b0 || bus.send_msg !== '0) begin failures++;
      $display("FAIL rst_mid_send got=%b/%h exp=0/0", bus.send_val, bus.send_msg); end
    checks++; if (bus.spi_ifc_miso !== 1'b0 || bus.recv_rdy !== 1'b1) begin failures++;
      $display("FAIL rst_mid_miso_rdy got=%b/%b exp=0/1", bus.spi_ifc_miso, bus.recv_rdy); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++;
      $display("FAIL rst_mid_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
    wait_clks(3);
    reset = 1'b1;
    // cs still low after release: must not be taken as a start
    push_recv(34'h0_DEAD_BEEF);
    wait_clks(10);
    for (int i = 0; i < 5; i++) begin
      bus.spi_ifc_sclk = 1'b1;
      wait_clks(6);
      bus.spi_ifc_sclk = 1'b0;
      wait_clks(6);
    end
    checks++; if (bus.recv_rdy !== 1'b0 || bus.underflow !== 1'b0) begin failures++;
      $display("FAIL rst_mid_no_start got=%b/%b exp=0/0", bus.recv_rdy, bus.underflow); end
    bus.spi_ifc_cs = 1'b1;
    wait_clks(10);
    spi_xfer(34'h2_0000_0003, NBits, 1'b1, cap);
    checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 34'h2_0000_0003) begin failures++;
      $display("FAIL rst_mid_after got=%b/%h exp=1/%h", bus.send_val, bus.send_msg,
               34'h2_0000_0003); end
    checks++; if (cap !== 34'h0_DEAD_BEEF) begin failures++;
      $display("FAIL rst_mid_after_miso got=%h exp=%h", cap, 34'h0_DEAD_BEEF); end
    pop_send();
  endtask

  task automatic test_long_window();
    logic [NBits-1:0] cap;
    push_recv(34'h2_5A5A_A5A5);
    spi_xfer(34'h1_8421_0F0F, 40, 1'b1, cap);
    checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 34'h1_8421_0F0F) begin failures++;
      $display("FAIL long_send got=%b/%h exp=1/%h", bus.send_val, bus.send_msg,
               34'h1_8421_0F0F); end
    checks++; if (bus.overflow !== 1'b0) begin failures++;
      $display("FAIL long_overflow got=%b exp=0", bus.overflow); end
    checks++; if (cap !== 34'h2_5A5A_A5A5) begin failures++;
      $display("FAIL long_miso got=%h exp=%h", cap, 34'h2_5A5A_A5A5); end
    pop_send();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    clk              = 1'b0;
    reset            = 1'b0;
    bus.spi_ifc_cs   = 1'b1;
    bus.spi_ifc_sclk = 1'b0;
    bus.spi_ifc_mosi = 1'b0;
    bus.recv_val     = 1'b0;
    bus.recv_msg     = '0;
    bus.send_rdy     = 1'b0;
    bus.flag_clr     = 1'b0;
    wait_clks(3);
    test_reset();
    reset = 1'b1;
    wait_clks(8);
    test_basic();
    test_back_to_back();
    test_underflow();
    test_abort();
    test_reset_mid();
    test_long_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
